// File: rtl/fetch_unit.sv
// SAP-1 fetch datapath: program counter, memory address register, instruction
// register and ALU flags, driven by the controller's control-word bits.
module fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              co,
  input  logic              ci,
  input  logic              jmp,
  input  logic              jc,
  input  logic              jz,
  input  logic              mi,
  input  logic              ii,
  input  logic              io,
  input  logic              fi,
  input  logic              hlt,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [OP_W-1:0]   opcode,
  output logic              flag_c,
  output logic              flag_z,
  output logic              bus_conflict
);

  localparam int PAD_W = DATA_W - ADDR_W;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic              flag_c_q;
  logic              flag_z_q;
  logic              conflict_q;
  logic              take;

  // Jump decision uses the registered flags, so a same-edge fi cannot steer it.
  assign take = jmp | (jc & flag_c_q) | (jz & flag_z_q);

  // co has priority when both drivers are requested.
  always_comb begin
    bus_out = '0;
    if (co) begin
      bus_out = {{PAD_W{1'b0}}, pc_q};
    end else if (io) begin
      bus_out = {{PAD_W{1'b0}}, ir_q[ADDR_W-1:0]};
    end
  end

  assign bus_oe = co | io;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the whole register set, flags included, is
  // cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else if (!hlt) begin
      if (take) begin
        pc_q <= bus_in[ADDR_W-1:0];
      end else if (ci) begin
        pc_q <= pc_q + ADDR_W'(1);
      end

      if (mi) begin
        mar_q <= bus_in[ADDR_W-1:0];
      end

      if (ii) begin
        ir_q <= bus_in;
      end

      if (fi) begin
        flag_c_q <= alu_carry;
        flag_z_q <= alu_zero;
      end

      if (co && io) begin
        conflict_q <= 1'b1;
      end
    end
  end

  assign mem_addr     = mar_q;
  assign pc           = pc_q;
  assign opcode       = ir_q[DATA_W-1 -: OP_W];
  assign flag_c       = flag_c_q;
  assign flag_z       = flag_z_q;
  assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: one task per feature, each
// comparing outputs against hand-computed values.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       co, ci, jmp, jc, jz, mi, ii, io, fi, hlt;
  logic       alu_carry, alu_zero;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [3:0] mem_addr;
  logic [3:0] pc;
  logic [3:0] opcode;
  logic       flag_c, flag_z, bus_conflict;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.ADDR_W(4), .DATA_W(8), .OP_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_in       (bus_in),
    .co           (co),
    .ci           (ci),
    .jmp          (jmp),
    .jc           (jc),
    .jz           (jz),
    .mi           (mi),
    .ii           (ii),
    .io           (io),
    .fi           (fi),
    .hlt          (hlt),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .mem_addr     (mem_addr),
    .pc           (pc),
    .opcode       (opcode),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .bus_conflict (bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus_in = 8'h00; co = 0; ci = 0; jmp = 0; jc = 0; jz = 0; mi = 0;
    ii = 0; io = 0; fi = 0; hlt = 0; alu_carry = 0; alu_zero = 0;
  endtask

  // Advance one posedge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (pc !== 4'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_cmp++; if (mem_addr !== 4'h0) begin n_err++; $display("FAIL reset_mar: got %h want 0", mem_addr); end
    n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL reset_opcode: got %h want 0", opcode); end
    n_cmp++; if ({flag_c, flag_z, bus_conflict} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {flag_c, flag_z, bus_conflict}); end
    n_cmp++; if ({bus_oe, bus_out} !== 9'h000) begin n_err++; $display("FAIL reset_bus: got oe=%b out=%h want oe=0 out=00", bus_oe, bus_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pc_increment();
    ci = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (pc !== 4'(i)) begin n_err++; $display("FAIL pc_inc_%0d: got %0d want %0d", i, pc, i); end
    end
    ci = 0;
  endtask

  task automatic test_wrap_and_load();
    jmp = 1; bus_in = 8'h0F;
    tick();
    n_cmp++; if (pc !== 4'hF) begin n_err++; $display("FAIL pc_load15: got %h want f", pc); end
    jmp = 0; ci = 1;
    tick();
    n_cmp++; if (pc !== 4'h0) begin n_err++; $display("FAIL pc_wrap: got %h want 0", pc); end
    ci = 0; jmp = 1; bus_in = 8'hA5;  // upper nibble must be ignored
    tick();
    n_cmp++; if (pc !== 4'h5) begin n_err++; $display("FAIL pc_load_upper_ignored: got %h want 5", pc); end
    jmp = 0;
  endtask

  task automatic test_bus_drive_mar();
    co = 1;
    #1;
    n_cmp++; if ({bus_oe, bus_out} !== {1'b1, 8'h05}) begin n_err++; $display("FAIL co_drive: got oe=%b out=%h want oe=1 out=05", bus_oe, bus_out); end
    mi = 1; bus_in = 8'h05;
    tick();
    n_cmp++; if (mem_addr !== 4'h5) begin n_err++; $display("FAIL mar_load: got %h want 5", mem_addr); end
    n_cmp++; if (pc !== 4'h5) begin n_err++; $display("FAIL pc_hold_during_mi: got %h want 5", pc); end
    mi = 0;
    // Loopback: PC onto bus and straight back with jmp; increment suppressed.
    jmp = 1; ci = 1; bus_in = 8'h05;
    tick();
    n_cmp++; if (pc !== 4'h5) begin n_err++; $display("FAIL loopback: got %h want 5", pc); end
    clear_inputs();
    #1;
    n_cmp++; if ({bus_oe, bus_out} !== 9'h000) begin n_err++; $display("FAIL bus_idle: got oe=%b out=%h want oe=0 out=00", bus_oe, bus_out); end
  endtask

  task automatic test_ir();
    ii = 1; bus_in = 8'h2E;
    tick();
    n_cmp++; if (opcode !== 4'h2) begin n_err++; $display("FAIL ir_opcode: got %h want 2", opcode); end
    ii = 0; io = 1;
    #1;
    n_cmp++; if ({bus_oe, bus_out} !== {1'b1, 8'h0E}) begin n_err++; $display("FAIL io_drive: got oe=%b out=%h want oe=1 out=0e", bus_oe, bus_out); end
    io = 0; mi = 1; ii = 1; bus_in = 8'h3B;
    tick();
    n_cmp++; if ({opcode, mem_addr} !== 8'h3B) begin n_err++; $display("FAIL mi_ii_same_bus: got op=%h mar=%h want op=3 mar=b", opcode, mem_addr); end
    clear_inputs();
  endtask

  task automatic test_flags_jumps();
    fi = 1; alu_carry = 1; alu_zero = 0;
    tick();
    n_cmp++; if ({flag_c, flag_z} !== 2'b10) begin n_err++; $display("FAIL flags_load: got c=%b z=%b want c=1 z=0", flag_c, flag_z); end
    clear_inputs(); jc = 1; bus_in = 8'h09;
    tick();
    n_cmp++; if (pc !== 4'h9) begin n_err++; $display("FAIL jc_taken: got %h want 9", pc); end
    clear_inputs(); jz = 1; ci = 1; bus_in = 8'h03;
    tick();
    n_cmp++; if (pc !== 4'hA) begin n_err++; $display("FAIL jz_not_taken: got %h want a", pc); end
    clear_inputs();
  endtask

  task automatic test_same_edge_flags();
    fi = 1; alu_zero = 1; alu_carry = 0; jz = 1; bus_in = 8'h01;
    tick();
    n_cmp++; if (pc !== 4'hA) begin n_err++; $display("FAIL jz_preedge_flag: got %h want a", pc); end
    n_cmp++; if ({flag_c, flag_z} !== 2'b01) begin n_err++; $display("FAIL flags_after_fi: got c=%b z=%b want c=0 z=1", flag_c, flag_z); end
    clear_inputs(); jz = 1; bus_in = 8'h0C;
    tick();
    n_cmp++; if (pc !== 4'hC) begin n_err++; $display("FAIL jz_taken: got %h want c", pc); end
    clear_inputs();
  endtask

  task automatic test_hlt();
    hlt = 1; ci = 1; mi = 1; ii = 1; fi = 1; jmp = 1; co = 1; io = 1;
    alu_carry = 1; alu_zero = 0; bus_in = 8'hF7;
    #1;
    n_cmp++; if ({bus_oe, bus_out} !== {1'b1, 8'h0C}) begin n_err++; $display("FAIL hlt_bus_drive: got oe=%b out=%h want oe=1 out=0c", bus_oe, bus_out); end
    tick();
    tick();
    n_cmp++; if ({pc, mem_addr, opcode} !== 12'hCB3) begin n_err++; $display("FAIL hlt_regs: got pc=%h mar=%h op=%h want pc=c mar=b op=3", pc, mem_addr, opcode); end
    n_cmp++; if ({flag_c, flag_z, bus_conflict} !== 3'b010) begin n_err++; $display("FAIL hlt_flags: got %b want 010", {flag_c, flag_z, bus_conflict}); end
    clear_inputs();
  endtask

  task automatic test_conflict();
    co = 1; io = 1;
    #1;
    n_cmp++; if ({bus_oe, bus_out} !== {1'b1, 8'h0C}) begin n_err++; $display("FAIL conflict_co_wins: got oe=%b out=%h want oe=1 out=0c", bus_oe, bus_out); end
    n_cmp++; if (bus_conflict !== 1'b0) begin n_err++; $display("FAIL conflict_before_edge: got %b want 0", bus_conflict); end
    tick();
    n_cmp++; if (bus_conflict !== 1'b1) begin n_err++; $display("FAIL conflict_set: got %b want 1", bus_conflict); end
    clear_inputs();
    tick();
    tick();
    n_cmp++; if (bus_conflict !== 1'b1) begin n_err++; $display("FAIL conflict_sticky: got %b want 1", bus_conflict); end
  endtask

  task automatic test_async_reset();
    jmp = 1; bus_in = 8'h07;
    tick();
    n_cmp++; if (pc !== 4'h7) begin n_err++; $display("FAIL pc_load7: got %h want 7", pc); end
    clear_inputs();
    #1;
    rst_n = 1'b0;  // mid-cycle, clock high, no edge pending
    #1;
    n_cmp++; if (pc !== 4'h0) begin n_err++; $display("FAIL async_reset_pc: got %h want 0", pc); end
    n_cmp++; if ({bus_conflict, flag_z, mem_addr, opcode} !== 10'h000) begin n_err++; $display("FAIL async_reset_state: got conf=%b z=%b mar=%h op=%h want all 0", bus_conflict, flag_z, mem_addr, opcode); end
    @(negedge clk);
    rst_n = 1'b1;
    ci = 1;
    tick();
    n_cmp++; if (pc !== 4'h1) begin n_err++; $display("FAIL post_reset_inc: got %h want 1", pc); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_pc_increment();
    test_wrap_and_load();
    test_bus_drive_mar();
    test_ir();
    test_flags_jumps();
    test_same_edge_flags();
    test_hlt();
    test_conflict();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
